// File: rtl/current_pi.sv
// Dual-axis PI current controller. A single Kp/Ki multiplier pair is time-shared between
// the d and q axes; each rising edge of iPI_en runs one sequential update.
module current_pi #(
  parameter int unsigned KP_SHIFT = 12,
  parameter int unsigned KI_SHIFT = 16,
  parameter int          INT_LIM  = 32000,
  parameter int          OUT_LIM  = 32000
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iPI_en,
  input  logic               iPI_clr,
  input  logic signed [11:0] iId,
  input  logic signed [11:0] iIq,
  input  logic signed [11:0] iId_ref,
  input  logic signed [11:0] iIq_ref,
  input  logic        [15:0] iKp,
  input  logic        [15:0] iKi,
  output logic signed [15:0] oVd,
  output logic signed [15:0] oVq,
  output logic               oPI_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_D_MUL,
    S_D_ACC,
    S_Q_MUL,
    S_Q_ACC,
    S_OUT
  } state_e;

  localparam logic signed [30:0] IntLim = 31'(INT_LIM);
  localparam logic signed [30:0] OutLim = 31'(OUT_LIM);

  state_e             state_q, state_d;
  logic               en_prev_q;
  logic signed [12:0] ed_q, ed_d;
  logic signed [12:0] eq_q, eq_d;
  logic        [15:0] kp_q, kp_d;
  logic        [15:0] ki_q, ki_d;
  logic signed [29:0] pd_q, pd_d;
  logic signed [29:0] pq_q, pq_d;
  logic signed [29:0] inc_q, inc_d;
  logic signed [15:0] acc_d_q, acc_d_d;
  logic signed [15:0] acc_q_q, acc_q_d;
  logic signed [15:0] vd_q, vd_d;
  logic signed [15:0] vq_q, vq_d;
  logic               done_q, done_d;

  logic               trig;
  logic signed [12:0] err_sel;
  logic signed [29:0] mul_p, mul_i;
  logic signed [29:0] prop, incr;
  logic signed [15:0] acc_sel;
  logic signed [30:0] acc_sum;
  logic signed [30:0] sum_vd, sum_vq;

  function automatic logic signed [15:0] sat16(input logic signed [30:0] v,
                                               input logic signed [30:0] lim);
    logic signed [30:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r[15:0];
  endfunction

  assign trig = iPI_en & ~en_prev_q;

  // Shared datapath: the state selects which axis feeds the multipliers and the accumulator.
  assign err_sel = (state_q == S_Q_MUL) ? eq_q : ed_q;
  assign mul_p   = $signed({14'b0, kp_q}) * $signed({{17{err_sel[12]}}, err_sel});
  assign mul_i   = $signed({14'b0, ki_q}) * $signed({{17{err_sel[12]}}, err_sel});
  assign prop    = mul_p >>> KP_SHIFT;
  assign incr    = mul_i >>> KI_SHIFT;

  assign acc_sel = (state_q == S_Q_ACC) ? acc_q_q : acc_d_q;
  assign acc_sum = $signed({{15{acc_sel[15]}}, acc_sel}) + $signed({inc_q[29], inc_q});
  assign sum_vd  = $signed({pd_q[29], pd_q}) + $signed({{15{acc_d_q[15]}}, acc_d_q});
  assign sum_vq  = $signed({pq_q[29], pq_q}) + $signed({{15{acc_q_q[15]}}, acc_q_q});

  always_comb begin
    state_d = state_q;
    ed_d    = ed_q;
    eq_d    = eq_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    pd_d    = pd_q;
    pq_d    = pq_q;
    inc_d   = inc_q;
    acc_d_d = acc_d_q;
    acc_q_d = acc_q_q;
    vd_d    = vd_q;
    vq_d    = vq_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A clear request takes priority and swallows a coincident trigger.
        if (iPI_clr) begin
          acc_d_d = '0;
          acc_q_d = '0;
        end else if (trig) begin
          ed_d    = {iId_ref[11], iId_ref} - {iId[11], iId};
          eq_d    = {iIq_ref[11], iIq_ref} - {iIq[11], iIq};
          kp_d    = iKp;
          ki_d    = iKi;
          state_d = S_D_MUL;
        end
      end
      S_D_MUL: begin
        pd_d    = prop;
        inc_d   = incr;
        state_d = S_D_ACC;
      end
      S_D_ACC: begin
        acc_d_d = sat16(acc_sum, IntLim);
        state_d = S_Q_MUL;
      end
      S_Q_MUL: begin
        pq_d    = prop;
        inc_d   = incr;
        state_d = S_Q_ACC;
      end
      S_Q_ACC: begin
        acc_q_d = sat16(acc_sum, IntLim);
        state_d = S_OUT;
      end
      S_OUT: begin
        vd_d    = sat16(sum_vd, OutLim);
        vq_d    = sat16(sum_vq, OutLim);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      en_prev_q <= 1'b0;
      ed_q      <= '0;
      eq_q      <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      pd_q      <= '0;
      pq_q      <= '0;
      inc_q     <= '0;
      acc_d_q   <= '0;
      acc_q_q   <= '0;
      vd_q      <= '0;
      vq_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= iPI_en;
      ed_q      <= ed_d;
      eq_q      <= eq_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
      pd_q      <= pd_d;
      pq_q      <= pq_d;
      inc_q     <= inc_d;
      acc_d_q   <= acc_d_d;
      acc_q_q   <= acc_q_d;
      vd_q      <= vd_d;
      vq_q      <= vq_d;
      done_q    <= done_d;
    end
  end

  assign oVd      = vd_q;
  assign oVq      = vq_q;
  assign oPI_done = done_q;

endmodule
